// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the CPU/accelerator data-memory arbiter.
package dmem_arb_pkg;
   typedef enum logic [1:0] {S_IDLE, S_CPU, S_ACC} arb_state_t;
   typedef enum logic {OWN_CPU, OWN_ACC} owner_t;
   typedef struct packed {logic vld; owner_t own;} rd_tag_t;
endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// dmem_rd_tag_pipe: RD_LAT-deep shift register carrying read ownership tags.
module dmem_rd_tag_pipe
   import dmem_arb_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    clk,
   input  logic    rst_n,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);
   rd_tag_t [RD_LAT-1:0] sr;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr <= '0;
      else begin
         sr[0] <= tag_in;
         for (int i = 1; i < RD_LAT; i++) sr[i] <= sr[i-1];
      end
   assign tag_out = sr[RD_LAT-1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: one-access-per-cycle arbiter between CPU and accelerator DMA
// for a single-port data memory, with bounded starvation both ways.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 8,
   parameter int MAX_WAIT  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              acc_req,
   input  logic              acc_wr,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [DATA_W-1:0] acc_wdata,
   output logic              acc_gnt,
   output logic [DATA_W-1:0] acc_rdata,
   output logic              acc_rvalid,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);
   localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
   arb_state_t state;
   logic [BW-1:0] burst_cnt;
   logic [WW-1:0] wait_cnt;
   logic cpu_grant, acc_grant, cpu_hit, acc_hit;
   logic [DATA_W-1:0] cpu_rdata_q, acc_rdata_q;
   rd_tag_t tag_in, tag_out;
   // Grants are gated by rst_n so nothing reaches memory while in reset.
   assign acc_grant = rst_n & acc_req &
                      ((wait_cnt == WMAX) | ~cpu_req | ((state == S_ACC) & (burst_cnt < BMAX)));
   assign cpu_grant = rst_n & cpu_req & ~acc_grant;
   assign cpu_stall = cpu_req & ~cpu_grant;
   assign acc_gnt   = acc_grant;
   assign mem_en    = cpu_grant | acc_grant;
   assign mem_wr    = acc_grant ? acc_wr : cpu_grant & cpu_wr;
   assign mem_addr  = acc_grant ? acc_addr : cpu_grant ? cpu_addr : '0;
   assign mem_wdata = acc_grant ? acc_wdata : cpu_grant ? cpu_wdata : '0;
   assign tag_in = '{vld: mem_en & ~mem_wr, own: acc_grant ? OWN_ACC : OWN_CPU};
   dmem_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );
   assign cpu_hit    = tag_out.vld & (tag_out.own == OWN_CPU);
   assign acc_hit    = tag_out.vld & (tag_out.own == OWN_ACC);
   assign cpu_rvalid = cpu_hit;
   assign acc_rvalid = acc_hit;
   assign cpu_rdata  = cpu_hit ? mem_rdata : cpu_rdata_q;
   assign acc_rdata  = acc_hit ? mem_rdata : acc_rdata_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= S_IDLE;
         burst_cnt   <= '0;
         wait_cnt    <= '0;
         cpu_rdata_q <= '0;
         acc_rdata_q <= '0;
      end else begin
         state       <= acc_grant ? S_ACC : cpu_grant ? S_CPU : S_IDLE;
         burst_cnt   <= !acc_grant ? '0 : (state != S_ACC) ? BW'(1) :
                        (burst_cnt == BMAX) ? BMAX : burst_cnt + 1'b1;
         wait_cnt    <= (acc_req & ~acc_grant) ? ((wait_cnt == WMAX) ? WMAX : wait_cnt + 1'b1) : '0;
         cpu_rdata_q <= cpu_rdata;
         acc_rdata_q <= acc_rdata;
      end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU load/store port and the NN accelerator DMA port inside cpu_dmem_acc_wrapper.
- Grants one access per cycle and stalls the losing requester.
- Routes read data back to the requester that issued the read, tagged by a read-latency pipeline.
- Bounds starvation in both directions: accelerator bursts are capped, and accelerator waiting is capped.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- RD_LAT, 1, data-memory read latency in cycles (≥1).
- MAX_BURST, 8, max consecutive accelerator grants while cpu_req is pending.
- MAX_WAIT, 4, max consecutive cycles acc_req may be denied before it is forced a grant.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU memory access request (dmem_ren | dmem_wren).
- cpu_wr  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  cpu_req pending and not granted this cycle.
- cpu_rdata  out  DATA_W  read data to CPU.
- cpu_rvalid  out  1  cpu_rdata valid.
- acc_req  in  1  accelerator access request.
- acc_wr  in  1  1=write.
- acc_addr  in  ADDR_W  accelerator address.
- acc_wdata  in  DATA_W  accelerator write data.
- acc_gnt  out  1  accelerator access accepted this cycle.
- acc_rdata  out  DATA_W  read data to accelerator.
- acc_rvalid  out  1  acc_rdata valid.
- mem_en  out  1  memory access this cycle.
- mem_wr  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after a read.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset state:
  - state=S_IDLE; burst_cnt=0; wait_cnt=0; read-tag pipeline cleared.
  - cpu_rvalid=0, acc_rvalid=0, acc_gnt=0, mem_en=0.
  - cpu_stall = cpu_req (no grant while in reset).
  - Reset asserted mid-operation drops in-flight read tags; no rvalid is produced for them.
- Grant decision is combinational from the registered state and counters plus the current requests. The access goes to memory in the same cycle. Sequential state updates on the rising edge.
- States:
  - S_IDLE: last cycle had no grant.
  - S_CPU: last grant went to the CPU.
  - S_ACC: last grant went to the accelerator.
- Grant rules, in priority order:
  1. acc_req & wait_cnt==MAX_WAIT → ACC.
  2. state==S_ACC & acc_req & (~cpu_req | burst_cnt<MAX_BURST) → ACC (burst continues).
  3. cpu_req → CPU.
  4. acc_req → ACC.
  5. Otherwise no grant.
- Next state = S_CPU / S_ACC / S_IDLE according to the grant.
- burst_cnt:
  - Increments on an ACC grant while state==S_ACC, saturating at MAX_BURST.
  - Set to 1 on an ACC grant from any other state.
  - Reset to 0 on a CPU grant or no grant.
- wait_cnt:
  - Increments when acc_req and not granted, saturating at MAX_WAIT.
  - Cleared on an ACC grant or when acc_req=0.
- Outputs:
  - cpu_stall = cpu_req & ~cpu_grant. acc_gnt = acc_grant.
  - mem_* is muxed from the granted port. mem_en = any grant; mem_wr follows the granted port's wr.
  - With no grant, mem_addr and mem_wdata are driven to 0.
- Read return:
  - A read grant pushes tag {valid, owner} into an RD_LAT-deep shift register.
  - At the pipeline output, cpu_rvalid or acc_rvalid is asserted for exactly one cycle.
  - The rdata of the owning port equals mem_rdata; the other port's rdata holds its previous value.
  - Writes push invalid tags.
- Simultaneous events:
  - Both ports requesting the same address is not special-cased; accesses are serialised.
  - A write followed next cycle by a read to the same address returns the new data.
- Requesters hold req/wr/addr/wdata stable until granted. The arbiter does not latch ungranted requests.
- Counter widths are $clog2(MAX_BURST+1) and $clog2(MAX_WAIT+1).

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_CPU, S_ACC} arb_state_t.
  - typedef enum logic {OWN_CPU, OWN_ACC} owner_t.
  - typedef struct packed {logic vld; owner_t own;} rd_tag_t.
- One sub-module, dmem_rd_tag_pipe: the RD_LAT-deep rd_tag_t shift register with async clear.

Test Plan:
1. Reset: rst_n=0 with cpu_req=1 → cpu_stall=1, mem_en=0, both rvalid=0. Release → CPU granted on first edge.
2. CPU read alone: addr 0x0010, mem holds 0xBEEF → mem_en=1, mem_wr=0 that cycle; cpu_rvalid=1, cpu_rdata=0xBEEF one cycle later; acc_rvalid stays 0.
3. Contention from S_IDLE: cpu_req and acc_req rise together, both held → CPU granted cycles 0..3; forced ACC grant at cycle 4 (wait_cnt=4); burst continues while acc_req and burst_cnt<8.
4. Accelerator burst: acc streams 20 reads in S_ACC; cpu_req rises at access 3 → ACC gets accesses up to burst_cnt=8, then CPU gets one grant with cpu_stall low, then ACC resumes.
5. Read routing: back-to-back ACC read 0x0100 (0x1111), CPU read 0x0200 (0x2222) → acc_rvalid with 0x1111 then cpu_rvalid with 0x2222 on consecutive cycles; never both asserted.
6. Reset mid-read: assert rst_n=0 the cycle after an ACC read grant → no acc_rvalid; all counters at 0 after release.
